// File: rtl/pc_pkg.sv
// pc_pkg: next-PC source encoding and default sequencer constants
package pc_pkg;
    typedef enum logic [2:0] {
        PC_SRC_HOLD,
        PC_SRC_SEQ,
        PC_SRC_REDIR,
        PC_SRC_PEND,
        PC_SRC_EXC
    } pc_src_t;
    localparam int          PC_ADDR_W    = 32;
    localparam logic [31:0] PC_RESET_VEC = 32'h0000_0000;
    localparam logic [31:0] PC_EXC_VEC   = 32'h0000_0180;
    localparam int          PC_INC       = 4;
endpackage

// File: rtl/pc_pend_buf.sv
// pc_pend_buf: one-entry buffer holding a redirect target that arrived during a stall
module pc_pend_buf #(
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              capture,
    input  logic              clear,
    input  logic [ADDR_W-1:0] din,
    output logic              valid,
    output logic [ADDR_W-1:0] target
);
    always_ff @(posedge clk or posedge reset)
        if (reset) begin
            valid  <= 1'b0;
            target <= '0;
        end else if (capture) begin
            valid  <= 1'b1;
            target <= din;
        end else if (clear)
            valid <= 1'b0;
endmodule

// File: rtl/pc_seq_unit.sv
// pc_seq_unit: fetch PC sequencer with redirect/exception priority and stall-held redirect buffer.
// Define PC_ALIGN_CHECK_EN to replace misaligned targets with the exception vector.
module pc_seq_unit
    import pc_pkg::*;
#(
    parameter int                ADDR_W    = PC_ADDR_W,
    parameter logic [ADDR_W-1:0] RESET_VEC = ADDR_W'(PC_RESET_VEC),
    parameter logic [31:0]       EXC_VEC   = PC_EXC_VEC,
    parameter int                INC       = PC_INC
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              stall,
    input  logic              redirect_valid,
    input  logic [ADDR_W-1:0] redirect_target,
    input  logic              exc_valid,
    output logic [ADDR_W-1:0] fetch_pc,
    output logic              pc_valid,
    output logic              pc_redir,
    output logic              pend_valid,
    output logic              misalign
);
    localparam logic [ADDR_W-1:0] EXC_PC = ADDR_W'(EXC_VEC);
    pc_src_t           src;
    logic [ADDR_W-1:0] pend_target, tgt, next_pc;
    logic              bad, load;
    always_comb begin
        src = exc_valid                   ? PC_SRC_EXC   :
              redirect_valid && !stall    ? PC_SRC_REDIR :
              redirect_valid              ? PC_SRC_HOLD  :
              !stall && pend_valid        ? PC_SRC_PEND  :
              !stall                      ? PC_SRC_SEQ   : PC_SRC_HOLD;
        tgt     = src == PC_SRC_PEND ? pend_target : redirect_target;
        load    = src == PC_SRC_REDIR || src == PC_SRC_PEND;
        next_pc = src == PC_SRC_EXC || bad ? EXC_PC :
                  load                     ? tgt :
                  src == PC_SRC_SEQ        ? fetch_pc + ADDR_W'(INC) : fetch_pc;
    end
`ifdef PC_ALIGN_CHECK_EN
    localparam logic [ADDR_W-1:0] AMASK = ADDR_W'((1 << $clog2(INC)) - 1);
    assign bad = load && |(tgt & AMASK);
    always_ff @(posedge clk or posedge reset)
        if (reset) misalign <= 1'b0;
        else misalign <= bad;
`else
    assign bad      = 1'b0;
    assign misalign = 1'b0;
`endif
    pc_pend_buf #(.ADDR_W(ADDR_W)) u_pend (
        .clk     (clk),
        .reset   (reset),
        .capture (redirect_valid && stall && !exc_valid),
        .clear   (src == PC_SRC_EXC || load),
        .din     (redirect_target),
        .valid   (pend_valid),
        .target  (pend_target)
    );
    always_ff @(posedge clk or posedge reset)
        if (reset) begin
            fetch_pc <= RESET_VEC;
            pc_valid <= 1'b0;
            pc_redir <= 1'b0;
        end else begin
            fetch_pc <= next_pc;
            pc_valid <= 1'b1;
            pc_redir <= src == PC_SRC_EXC || load;
        end
endmodule

// File: tb/tb_pc_seq_unit.sv
// tb_pc_seq_unit: directed and random checks of pc_seq_unit against a rule-level reference model
module tb_pc_seq_unit;
    logic        clk = 1'b0, reset = 1'b1, stall = 1'b0, redirect_valid = 1'b0, exc_valid = 1'b0;
    logic [31:0] redirect_target = '0, fetch_pc;
    logic        pc_valid, pc_redir, pend_valid, misalign;
    logic        reset8 = 1'b1, pc_valid8, pc_redir8, pend_valid8, misalign8;
    logic [7:0]  fetch_pc8;
    int          checks = 0, errors = 0;
    logic [31:0] m_pc, m_pt;
    logic        m_pv, m_redir, m_pend, m_mis;

    always #5 clk = ~clk;

    pc_seq_unit dut (
        .clk(clk), .reset(reset), .stall(stall), .redirect_valid(redirect_valid),
        .redirect_target(redirect_target), .exc_valid(exc_valid), .fetch_pc(fetch_pc),
        .pc_valid(pc_valid), .pc_redir(pc_redir), .pend_valid(pend_valid), .misalign(misalign)
    );

    pc_seq_unit #(.ADDR_W(8), .RESET_VEC(8'hF8)) dut8 (
        .clk(clk), .reset(reset8), .stall(1'b0), .redirect_valid(1'b0),
        .redirect_target(8'h00), .exc_valid(1'b0), .fetch_pc(fetch_pc8),
        .pc_valid(pc_valid8), .pc_redir(pc_redir8), .pend_valid(pend_valid8), .misalign(misalign8)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_pc = 32'h0; m_pt = 32'h0; m_pv = 0; m_redir = 0; m_pend = 0; m_mis = 0;
    endtask

    task automatic model_load(input logic [31:0] t);
        m_redir = 1;
`ifdef PC_ALIGN_CHECK_EN
        if (t % 4 != 0) begin
            m_pc  = 32'h180;
            m_mis = 1;
        end else
            m_pc = t;
`else
        m_pc = t;
`endif
    endtask

    task automatic model_next();
        m_redir = 0;
        m_mis   = 0;
        if (exc_valid) begin
            m_pc = 32'h180; m_pend = 0; m_redir = 1;
        end else if (redirect_valid && !stall) begin
            model_load(redirect_target); m_pend = 0;
        end else if (redirect_valid) begin
            m_pend = 1; m_pt = redirect_target;
        end else if (!stall && m_pend) begin
            model_load(m_pt); m_pend = 0;
        end else if (!stall)
            m_pc = m_pc + 32'd4;
        m_pv = 1;
    endtask

    task automatic compare_all(input string tag);
        check({tag, ".fetch_pc"}, fetch_pc, m_pc);
        check({tag, ".pc_valid"}, 32'(pc_valid), 32'(m_pv));
        check({tag, ".pc_redir"}, 32'(pc_redir), 32'(m_redir));
        check({tag, ".pend_valid"}, 32'(pend_valid), 32'(m_pend));
        check({tag, ".misalign"}, 32'(misalign), 32'(m_mis));
    endtask

    task automatic step(input string tag);
        model_next();
        @(posedge clk);
        #1;
        compare_all(tag);
    endtask

    initial begin
        model_reset();
        @(posedge clk);
        @(posedge clk);
        #1;
        compare_all("reset");
        reset = 0;
        for (int i = 0; i < 4; i++) step("free_run");
        while (m_pc != 32'h20) step("to_0x20");
        redirect_valid = 1; redirect_target = 32'h100;
        step("redirect_0x100");
        check("redirect_pc_literal", fetch_pc, 32'h100);
        redirect_valid = 0;
        step("after_redirect");
        check("seq_after_redirect", fetch_pc, 32'h104);
        stall = 1; redirect_valid = 1; redirect_target = 32'h200;
        step("stall_cap1");
        redirect_target = 32'h240;
        step("stall_cap2");
        redirect_valid = 0;
        step("stall_hold");
        stall = 0;
        step("pend_apply");
        check("pend_apply_literal", fetch_pc, 32'h240);
        stall = 1; redirect_valid = 1; redirect_target = 32'h200;
        step("exc_setup");
        exc_valid = 1; redirect_target = 32'h300;
        step("exc_wins");
        check("exc_vec_literal", fetch_pc, 32'h180);
        exc_valid = 0; redirect_valid = 0; stall = 0;
        step("after_exc");
        redirect_valid = 1; redirect_target = 32'h102;
        step("target_0x102");
        redirect_valid = 0;
        step("after_0x102");
        stall = 1; redirect_valid = 1; redirect_target = 32'h400;
        step("pre_reset_cap");
        redirect_valid = 0;
        #3 reset = 1;
        #1;
        model_reset();
        compare_all("async_reset");
        @(posedge clk);
        #1;
        compare_all("reset_held");
        reset = 0; stall = 0;
        for (int i = 0; i < 400; i++) begin
            stall           = ($urandom % 3) == 0;
            redirect_valid  = ($urandom % 4) == 0;
            redirect_target = $urandom & ((($urandom % 4) == 0) ? 32'hFFFF_FFFF : 32'hFFFF_FFFC);
            exc_valid       = ($urandom % 16) == 0;
            step("random");
        end
        stall = 0; redirect_valid = 0; exc_valid = 0;
        reset8 = 0;
        @(posedge clk);
        #1;
        check("w8_first", 32'(fetch_pc8), 32'hFC);
        @(posedge clk);
        #1;
        check("w8_wrap", 32'(fetch_pc8), 32'h00);
        check("w8_redir", 32'(pc_redir8), 32'h0);
        check("w8_valid", 32'(pc_valid8), 32'h1);
        check("w8_pend", 32'(pend_valid8), 32'h0);
        check("w8_misalign", 32'(misalign8), 32'h0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
